// File: rtl/tt_sweep_ctrl.sv
// Exhaustive sweep sequencer for a 3-input function block: steps {a,b,c} through
// all eight codes, samples f after a settle delay and checks it against a table.
module tt_sweep_ctrl #(
  parameter int SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] expected,
  input  logic       f,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] table_out,
  output logic [2:0] fail_idx
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_SAMPLE = 2'd2;
  localparam logic [1:0] S_FINISH = 2'd3;

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE - 1);

  logic [1:0] state;
  logic [2:0] idx;
  logic [7:0] cnt;
  logic [7:0] tbl;

  // Position of the lowest set bit; 0 when the vector is all zeros.
  function automatic logic [2:0] lowest_set(input logic [7:0] v);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) r = 3'(i);
    end
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      idx      <= 3'd0;
      cnt      <= 8'd0;
      tbl      <= 8'd0;
      pass     <= 1'b0;
      fail_idx <= 3'd0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            idx      <= 3'd0;
            cnt      <= 8'd0;
            tbl      <= 8'd0;
            pass     <= 1'b0;
            fail_idx <= 3'd0;
            state    <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          cnt <= cnt + 8'd1;
          if (cnt == SETTLE_LAST) state <= S_SAMPLE;
        end
        S_SAMPLE: begin
          tbl[idx] <= f;
          if (idx == 3'd7) begin
            state <= S_FINISH;
          end else begin
            idx   <= idx + 3'd1;
            cnt   <= 8'd0;
            state <= S_SETTLE;
          end
        end
        S_FINISH: begin
          pass     <= (tbl == expected);
          fail_idx <= lowest_set(tbl ^ expected);
          done     <= 1'b1;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // The code is forced to 000 in IDLE even though idx keeps its last value.
  assign {a, b, c}  = (state == S_IDLE) ? 3'b000 : idx;
  assign busy       = (state != S_IDLE);
  assign table_out  = tbl;

endmodule

// File: tb/tb_tt_sweep_ctrl.sv
// Bench for tt_sweep_ctrl: vector table of function/expected-table runs plus
// start-robustness, reset-abort and SETTLE=1 sequences, checked via a scoreboard.
module tb_tt_sweep_ctrl;

  localparam int SETTLE0 = 2;
  localparam int LAT0    = 8 * (SETTLE0 + 1) + 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start0 = 1'b0, start1 = 1'b0;
  logic [7:0] expected0 = 8'h00;
  logic [1:0] fsel = 2'd0;
  logic       f0, f1;
  logic       a0, b0, c0, busy0, done0, pass0;
  logic       a1, b1, c1, busy1, done1, pass1;
  logic [7:0] table_out0, table_out1;
  logic [2:0] fail_idx0, fail_idx1;

  int tests = 0;
  int fails = 0;
  int edge_n = 0;
  int m_start = -1000;

  typedef struct {
    logic [1:0] fsel;
    logic [7:0] expected;
    logic [7:0] tbl;
    logic       pass;
    logic [2:0] fail;
  } vec_t;

  typedef struct {
    logic [7:0] tbl;
    logic       pass;
    logic [2:0] fail;
    int         done_edge;
  } exp_t;

  vec_t vecs[8];
  exp_t sb[$];
  logic [7:0] cur_tbl = 8'h00;
  logic       cur_pass = 1'b0;
  logic [2:0] cur_fail = 3'd0;

  always #5 clk = ~clk;

  function automatic logic fmodel(input logic [1:0] sel, input logic x, input logic y, input logic z);
    case (sel)
      2'd0:    return (x & y) | (x & z) | (y & z);
      2'd1:    return x ^ y ^ z;
      2'd2:    return x & y & z;
      default: return 1'b0;
    endcase
  endfunction

  assign f0 = fmodel(fsel, a0, b0, c0);
  assign f1 = a1 ^ b1 ^ c1;

  tt_sweep_ctrl #(.SETTLE(SETTLE0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .expected(expected0), .f(f0),
    .a(a0), .b(b0), .c(c0), .busy(busy0), .done(done0), .pass(pass0),
    .table_out(table_out0), .fail_idx(fail_idx0)
  );

  tt_sweep_ctrl #(.SETTLE(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .expected(8'h96), .f(f1),
    .a(a1), .b(b1), .c(c1), .busy(busy1), .done(done1), .pass(pass1),
    .table_out(table_out1), .fail_idx(fail_idx1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  // Reference model of start acceptance; pushes the expected result of each run.
  initial forever begin
    @(posedge clk);
    edge_n++;
    if (rst) begin
      m_start = -1000;
      sb.delete();
    end else if (start0 && (edge_n - m_start > LAT0)) begin
      m_start = edge_n;
      sb.push_back('{cur_tbl, cur_pass, cur_fail, edge_n + LAT0});
    end
  end

  // Cycle monitor: busy and code sequence every cycle, results on done.
  initial forever begin
    int k;
    exp_t e;
    @(negedge clk);
    k = edge_n - m_start;
    chk("busy", 32'(busy0), 32'((k >= 0 && k < LAT0) ? 1 : 0));
    if (k >= 0 && k < LAT0 - 1)
      chk("abc_seq", 32'({a0, b0, c0}), 32'(k / (SETTLE0 + 1)));
    else if (k >= LAT0)
      chk("abc_idle", 32'({a0, b0, c0}), 32'd0);
    if (done0) begin
      if (sb.size() == 0) begin
        chk("spurious_done", 32'(done0), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("done_edge", 32'(edge_n), 32'(e.done_edge));
        chk("table_out", 32'(table_out0), 32'(e.tbl));
        chk("pass", 32'(pass0), 32'(e.pass));
        chk("fail_idx", 32'(fail_idx0), 32'(e.fail));
      end
    end else if (sb.size() > 0 && edge_n > sb[0].done_edge) begin
      e = sb.pop_front();
      chk("missing_done", 32'(done0), 32'd1);
    end
  end

  task automatic pulse_start();
    @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
  endtask

  task automatic wait_idle(input int maxc);
    int n = 0;
    while (sb.size() != 0 && n < maxc) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      chk("run_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  task automatic wait_k(input int n);
    int guard = 0;
    while (edge_n - m_start < n && guard < 200) begin
      @(negedge clk);
      guard++;
    end
  endtask

  task automatic set_vec(input vec_t v);
    fsel      = v.fsel;
    expected0 = v.expected;
    cur_tbl   = v.tbl;
    cur_pass  = v.pass;
    cur_fail  = v.fail;
  endtask

  initial begin
    int s1;
    bit seen;

    vecs[0] = '{2'd0, 8'hE8, 8'hE8, 1'b1, 3'd0};
    vecs[1] = '{2'd0, 8'hE9, 8'hE8, 1'b0, 3'd0};
    vecs[2] = '{2'd0, 8'h68, 8'hE8, 1'b0, 3'd7};
    vecs[3] = '{2'd0, 8'hEC, 8'hE8, 1'b0, 3'd2};
    vecs[4] = '{2'd1, 8'h96, 8'h96, 1'b1, 3'd0};
    vecs[5] = '{2'd1, 8'h97, 8'h96, 1'b0, 3'd0};
    vecs[6] = '{2'd2, 8'h00, 8'h80, 1'b0, 3'd7};
    vecs[7] = '{2'd2, 8'h81, 8'h80, 1'b0, 3'd0};

    // Reset held with start high: nothing may start.
    rst = 1'b1;
    start0 = 1'b1;
    start1 = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rst_abc", 32'({a0, b0, c0}), 32'd0);
      chk("rst_done", 32'(done0), 32'd0);
      chk("rst_pass", 32'(pass0), 32'd0);
      chk("rst_table", 32'(table_out0), 32'd0);
      chk("rst_fail_idx", 32'(fail_idx0), 32'd0);
      chk("rst_busy1", 32'(busy1), 32'd0);
    end
    rst = 1'b0;
    start0 = 1'b0;
    start1 = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      set_vec(vecs[i]);
      pulse_start();
      wait_idle(60);
      repeat (3) @(negedge clk);
      chk("pass_hold", 32'(pass0), 32'(vecs[i].pass));
      chk("fail_idx_hold", 32'(fail_idx0), 32'(vecs[i].fail));
    end

    // Start pulses while busy are ignored.
    set_vec(vecs[0]);
    pulse_start();
    wait_k(4);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    wait_k(11);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    wait_idle(60);
    repeat (3) @(negedge clk);

    // Level-held start: one done at 25, re-trigger on the done cycle.
    set_vec(vecs[2]);
    @(negedge clk);
    start0 = 1'b1;
    repeat (40) @(negedge clk);
    start0 = 1'b0;
    wait_idle(80);
    repeat (3) @(negedge clk);

    // Reset mid-run aborts without a done pulse.
    set_vec(vecs[0]);
    pulse_start();
    wait_k(9);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 32'(busy0), 32'd0);
    chk("abort_abc", 32'({a0, b0, c0}), 32'd0);
    chk("abort_table", 32'(table_out0), 32'd0);
    chk("abort_done", 32'(done0), 32'd0);
    repeat (30) @(negedge clk);
    pulse_start();
    wait_idle(60);
    repeat (2) @(negedge clk);
    chk("rerun_pass", 32'(pass0), 32'd1);

    // SETTLE=1 instance sweeping XOR.
    @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    s1 = edge_n;
    seen = 1'b0;
    for (int n = 0; n < 30 && !seen; n++) begin
      @(negedge clk);
      if (done1) begin
        seen = 1'b1;
        chk("s1_done_edge", 32'(edge_n - s1), 32'd17);
        chk("s1_table", 32'(table_out1), 32'h96);
        chk("s1_pass", 32'(pass1), 32'd1);
        chk("s1_fail_idx", 32'(fail_idx1), 32'd0);
      end
    end
    if (!seen) chk("s1_done_seen", 32'(seen), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running, expected finished");
    $fatal(1, "watchdog");
  end

endmodule
